// File: rtl/tx_msg_sequencer_1553_if.sv
// Bus bundle for the 1553 transmit sequencer: host control,
// word-buffer read port and encoder strobe/busy handshake.
interface tx_msg_sequencer_1553_if #(
    parameter int ADDR_W = 5
);
    logic              msg_start;
    logic [0:15]       msg_cmd;
    logic [ADDR_W:0]   msg_wc;
    logic              msg_abort;
    logic              msg_busy;
    logic              msg_done;
    logic              msg_err;
    logic              msg_aborted;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [0:15]       buf_rd_data;
    logic [0:15]       enc_dword;
    logic              enc_csw;
    logic              enc_dw;
    logic              enc_busy;

    modport master (
        input  msg_start, msg_cmd, msg_wc, msg_abort,
        input  buf_rd_data, enc_busy,
        output msg_busy, msg_done, msg_err, msg_aborted,
        output buf_rd_en, buf_rd_addr,
        output enc_dword, enc_csw, enc_dw
    );

    modport slave (
        output msg_start, msg_cmd, msg_wc, msg_abort,
        output buf_rd_data, enc_busy,
        input  msg_busy, msg_done, msg_err, msg_aborted,
        input  buf_rd_en, buf_rd_addr,
        input  enc_dword, enc_csw, enc_dw
    );
endinterface

// File: rtl/tx_msg_sequencer_1553.sv
// MIL-STD-1553 transmit message sequencer: command word, buffered
// data words, encoder ack/timeout, abort and inter-message gap.
module tx_msg_sequencer_1553 #(
    parameter int MAX_WORDS = 32,
    parameter int ADDR_W    = 5,
    parameter int GAP_CLKS  = 8,
    parameter int ACK_TO    = 4
) (
    input  logic enc_clk,
    input  logic rst,
    tx_msg_sequencer_1553_if.master bus
);
    localparam int CW = ADDR_W + 1;
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam int TW = $clog2(ACK_TO + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_CSW, SEND_DW, WAIT_ACK, WAIT_TX, GAP
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] wc_q;
    logic [CW-1:0] sent_q;
    logic [CW-1:0] sent_inc;
    logic [0:15]   hold_q;
    logic          rd_pend_q;
    logic          abort_q;
    logic          early_q;
    logic [TW-1:0] ack_cnt;
    logic [GW-1:0] gap_cnt;

    logic accept, bad_start, remain, abort_any;
    logic ack_timeout, tx_end, next_dw;
    logic gap_pre, gap_last;

    logic              busy_nxt, done_nxt, err_nxt, aborted_nxt;
    logic              csw_nxt, dw_nxt, rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [0:15]       dword_nxt;

    assign sent_inc  = sent_q + CW'(1);
    assign remain    = sent_q < wc_q;
    assign abort_any = abort_q | bus.msg_abort;

    assign accept = (state == IDLE) & bus.msg_start & ~bus.enc_busy
                  & (bus.msg_wc <= CW'(MAX_WORDS));
    assign bad_start = (state == IDLE) & bus.msg_start & ~accept;

    // the strobe cycle counts as the first cycle of the ack window
    assign ack_timeout = (state == WAIT_ACK) & ~bus.enc_busy
                       & (ack_cnt >= TW'(ACK_TO - 1));
    assign tx_end  = (state == WAIT_TX) & ~bus.enc_busy;
    assign next_dw = tx_end & remain & ~abort_any;

    assign gap_pre  = (state == GAP) & (gap_cnt == GW'(GAP_CLKS - 2));
    assign gap_last = (state == GAP) & (gap_cnt == GW'(GAP_CLKS - 1));

    always_ff @(posedge enc_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SEND_CSW;
            SEND_CSW,
            SEND_DW:  state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.enc_busy)     state_nxt = WAIT_TX;
                else if (ack_timeout) state_nxt = GAP;
            end
            WAIT_TX:  if (tx_end) state_nxt = next_dw ? SEND_DW : GAP;
            GAP:      if (gap_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        csw_nxt     = accept;
        dw_nxt      = next_dw;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = bus.buf_rd_addr;
        dword_nxt   = bus.enc_dword;
        if (csw_nxt) begin
            rd_en_nxt   = bus.msg_wc != '0;
            rd_addr_nxt = '0;
            dword_nxt   = bus.msg_cmd;
        end else if (dw_nxt) begin
            rd_en_nxt   = sent_inc < wc_q;
            rd_addr_nxt = sent_inc[ADDR_W-1:0];
            dword_nxt   = hold_q;
        end
        err_nxt     = bad_start | ack_timeout;
        done_nxt    = gap_pre;
        aborted_nxt = gap_pre & early_q;
        busy_nxt    = (state == IDLE) ? accept : ~(gap_pre | gap_last);
    end

    always_ff @(posedge enc_clk or posedge rst) begin
        if (rst) begin
            bus.msg_busy    <= 1'b0;
            bus.msg_done    <= 1'b0;
            bus.msg_err     <= 1'b0;
            bus.msg_aborted <= 1'b0;
            bus.buf_rd_en   <= 1'b0;
            bus.buf_rd_addr <= '0;
            bus.enc_dword   <= '0;
            bus.enc_csw     <= 1'b0;
            bus.enc_dw      <= 1'b0;
            wc_q            <= '0;
            sent_q          <= '0;
            hold_q          <= '0;
            rd_pend_q       <= 1'b0;
            abort_q         <= 1'b0;
            early_q         <= 1'b0;
            ack_cnt         <= '0;
            gap_cnt         <= '0;
        end else begin
            bus.msg_busy    <= busy_nxt;
            bus.msg_done    <= done_nxt;
            bus.msg_err     <= err_nxt;
            bus.msg_aborted <= aborted_nxt;
            bus.buf_rd_en   <= rd_en_nxt;
            bus.buf_rd_addr <= rd_addr_nxt;
            bus.enc_dword   <= dword_nxt;
            bus.enc_csw     <= csw_nxt;
            bus.enc_dw      <= dw_nxt;

            rd_pend_q <= bus.buf_rd_en;
            if (rd_pend_q) hold_q <= bus.buf_rd_data;

            if (accept) begin
                wc_q    <= bus.msg_wc;
                sent_q  <= '0;
                abort_q <= 1'b0;
                early_q <= 1'b0;
            end else begin
                if (state != IDLE && bus.msg_abort) abort_q <= 1'b1;
                // aborted only if words were actually left unsent
                if (ack_timeout || (tx_end && remain && abort_any))
                    early_q <= 1'b1;
                if (dw_nxt) sent_q <= sent_inc;
            end

            if (state == SEND_CSW || state == SEND_DW)
                ack_cnt <= TW'(1);
            else if (state == WAIT_ACK && ack_cnt < TW'(ACK_TO))
                ack_cnt <= ack_cnt + TW'(1);

            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
        end
    end
endmodule

// File: tb/tb_tx_msg_sequencer_1553.sv
// Bench for tx_msg_sequencer_1553: directed messages, encoder and
// buffer responders, event scoreboard with timing checks.
module tb_tx_msg_sequencer_1553;
    localparam int MAXW  = 32;
    localparam int AW    = 5;
    localparam int GAP   = 8;
    localparam int ATO   = 4;
    localparam int PITCH = 41;

    localparam int K_ERR  = 0;
    localparam int K_CSW  = 1;
    localparam int K_DW   = 2;
    localparam int K_RD   = 3;
    localparam int K_DONE = 4;

    localparam int R_NONE = 0;
    localparam int R_STRB = 1;
    localparam int R_FALL = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          rel;
        int          dly;
    } exp_t;

    logic enc_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 enc_clk = ~enc_clk;

    tx_msg_sequencer_1553_if #(.ADDR_W(AW)) bus ();

    tx_msg_sequencer_1553 #(
        .MAX_WORDS(MAXW),
        .ADDR_W   (AW),
        .GAP_CLKS (GAP),
        .ACK_TO   (ATO)
    ) dut (
        .enc_clk(enc_clk),
        .rst    (rst),
        .bus    (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          last_strb = 0;
    int          fall_cyc  = 0;
    logic        busy_prev = 1'b0;
    logic        enc_dead  = 1'b0;
    int          enc_rem   = 0;
    logic [15:0] mem [0:MAXW-1];
    exp_t        q [$];

    // encoder: busy for 39 cycles starting the cycle after a strobe
    always @(posedge enc_clk or posedge rst) begin
        if (rst) begin
            bus.enc_busy <= 1'b0;
            enc_rem      <= 0;
        end else if ((bus.enc_csw || bus.enc_dw) && !enc_dead) begin
            bus.enc_busy <= 1'b1;
            enc_rem      <= 38;
        end else if (bus.enc_busy) begin
            if (enc_rem == 0) bus.enc_busy <= 1'b0;
            else              enc_rem <= enc_rem - 1;
        end
    end

    always @(posedge enc_clk) begin
        if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
    end

    function automatic string kname(input int k);
        case (k)
            K_ERR:   return "err";
            K_CSW:   return "csw";
            K_DW:    return "dw";
            K_RD:    return "rd";
            default: return "done";
        endcase
    endfunction

    function automatic logic [31:0] outs();
        return {4'b0, bus.msg_busy, bus.msg_done, bus.msg_err,
                bus.msg_aborted, bus.buf_rd_en, bus.buf_rd_addr,
                bus.enc_dword, bus.enc_csw, bus.enc_dw};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val,
                        input int rel, input int dly);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.rel  = rel;
        e.dly  = dly;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [15:0] val);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: actual=%0h required=none (cycle %0d)",
                     kname(kind), val, cyc);
            return;
        end
        e = q.pop_front();
        chk({"event_kind_", kname(e.kind)}, kind, e.kind);
        if (kind == e.kind) begin
            chk({kname(kind), "_value"}, val, e.val);
            if (e.rel == R_STRB)
                chk({kname(kind), "_cycles_from_strobe"}, cyc - last_strb, e.dly);
            else if (e.rel == R_FALL)
                chk({kname(kind), "_cycles_from_busy_fall"}, cyc - fall_cyc, e.dly);
        end
    endtask

    initial begin
        forever begin
            @(negedge enc_clk);
            cyc++;
            if (!rst) begin
                if (bus.msg_err) observe(K_ERR, 16'h0);
                if (bus.enc_csw) begin
                    observe(K_CSW, bus.enc_dword);
                    last_strb = cyc;
                end
                if (bus.enc_dw) begin
                    observe(K_DW, bus.enc_dword);
                    last_strb = cyc;
                end
                if (bus.buf_rd_en) observe(K_RD, 16'(bus.buf_rd_addr));
                if (bus.msg_done) observe(K_DONE, 16'(bus.msg_aborted));
                if (busy_prev && !bus.enc_busy) fall_cyc = cyc;
                busy_prev = bus.enc_busy;
            end
        end
    end

    task automatic tick();
        @(posedge enc_clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick();
        while ((bus.msg_busy || bus.msg_done || bus.enc_busy) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_wait: actual=busy required=idle", name);
        end
    endtask

    task automatic wait_q(input int sz, input string name);
        int n = 0;
        while (q.size() > sz && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_event_wait: actual=%0d required=%0d",
                     name, q.size(), sz);
        end
    endtask

    task automatic start_msg(input logic [15:0] cmd, input logic [5:0] wc);
        wait_idle("start");
        bus.msg_cmd   = cmd;
        bus.msg_wc    = wc;
        bus.msg_start = 1'b1;
        tick();
        bus.msg_start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.msg_abort = 1'b1;
        tick();
        bus.msg_abort = 1'b0;
    endtask

    initial begin
        bus.msg_start = 1'b0;
        bus.msg_cmd   = '0;
        bus.msg_wc    = '0;
        bus.msg_abort = 1'b0;
        for (int i = 0; i < MAXW; i++) mem[i] = '0;

        #12;
        chk("reset_outputs", outs(), 32'h0);
        rst = 1'b0;
        tick();

        // abort in IDLE is ignored; then command-only message
        pulse_abort();
        tick();
        chk("idle_abort_busy", 32'(bus.msg_busy), 32'h0);
        push(K_CSW, 16'h1867, R_NONE, 0);
        push(K_DONE, 16'h0, R_FALL, GAP);
        start_msg(16'h1867, 6'd0);
        wait_idle("wc0");

        // three data words; a start pulse mid-message is ignored
        mem[0] = 16'hA5A5;
        mem[1] = 16'h0001;
        mem[2] = 16'hFFFF;
        push(K_CSW, 16'h0C23, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        push(K_DW, 16'hA5A5, R_STRB, PITCH);
        push(K_RD, 16'd1, R_NONE, 0);
        push(K_DW, 16'h0001, R_STRB, PITCH);
        push(K_RD, 16'd2, R_NONE, 0);
        push(K_DW, 16'hFFFF, R_STRB, PITCH);
        push(K_DONE, 16'h0, R_FALL, GAP);
        start_msg(16'h0C23, 6'd3);
        repeat (20) tick();
        bus.msg_cmd   = 16'hDEAD;
        bus.msg_wc    = 6'd1;
        bus.msg_start = 1'b1;
        tick();
        bus.msg_start = 1'b0;
        wait_idle("wc3");

        // full-length message
        for (int i = 0; i < MAXW; i++) mem[i] = 16'(i * 257) ^ 16'h8000;
        push(K_CSW, 16'h0820, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        for (int i = 0; i < MAXW; i++) begin
            push(K_DW, 16'(i * 257) ^ 16'h8000, R_STRB, PITCH);
            if (i < MAXW - 1) push(K_RD, 16'(i + 1), R_NONE, 0);
        end
        push(K_DONE, 16'h0, R_FALL, GAP);
        start_msg(16'h0820, 6'd32);
        wait_idle("wc32");

        // word count over the limit
        push(K_ERR, 16'h0, R_NONE, 0);
        start_msg(16'h0821, 6'd33);
        for (int i = 0; i < 3; i++) begin
            chk("bad_wc_busy", 32'(bus.msg_busy), 32'h0);
            tick();
        end
        wait_idle("wc33");

        // abort while word 2 is on the bus
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        mem[4] = 16'h5555;
        push(K_CSW, 16'h0C25, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        push(K_DW, 16'h1111, R_STRB, PITCH);
        push(K_RD, 16'd1, R_NONE, 0);
        push(K_DW, 16'h2222, R_STRB, PITCH);
        push(K_RD, 16'd2, R_NONE, 0);
        push(K_DW, 16'h3333, R_STRB, PITCH);
        push(K_RD, 16'd3, R_NONE, 0);
        push(K_DONE, 16'h1, R_FALL, GAP);
        start_msg(16'h0C25, 6'd5);
        wait_q(1, "abort");
        repeat (5) tick();
        pulse_abort();
        wait_idle("abort");

        // encoder never acknowledges
        enc_dead = 1'b1;
        push(K_CSW, 16'hBEEF, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        push(K_ERR, 16'h0, R_STRB, ATO);
        push(K_DONE, 16'h1, R_STRB, ATO + GAP - 1);
        start_msg(16'hBEEF, 6'd2);
        wait_idle("timeout");
        enc_dead = 1'b0;

        // reset in the middle of a data word
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[2] = 16'h9ABC;
        push(K_CSW, 16'h1863, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        push(K_DW, 16'h1234, R_STRB, PITCH);
        push(K_RD, 16'd1, R_NONE, 0);
        push(K_DW, 16'h5678, R_STRB, PITCH);
        push(K_RD, 16'd2, R_NONE, 0);
        push(K_DW, 16'h9ABC, R_STRB, PITCH);
        push(K_DONE, 16'h0, R_FALL, GAP);
        start_msg(16'h1863, 6'd3);
        wait_q(4, "pre_reset");
        repeat (10) tick();
        @(negedge enc_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_msg_reset_outputs", outs(), 32'h0);
        q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_reset_busy", 32'(bus.msg_busy), 32'h0);

        mem[0] = 16'h5A5A;
        push(K_CSW, 16'h2021, R_NONE, 0);
        push(K_RD, 16'd0, R_NONE, 0);
        push(K_DW, 16'h5A5A, R_STRB, PITCH);
        push(K_DONE, 16'h0, R_FALL, GAP);
        start_msg(16'h2021, 6'd1);
        wait_idle("post_reset");

        repeat (4) tick();
        chk("events_outstanding", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
